// File: rtl/wb_arbiter2_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM state, bundled
// master request, and the state-to-one-hot owner helper.
package wb_arbiter2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } wb_req_t;

  function automatic logic [1:0] owner_onehot(input state_e s);
    case (s)
      ST_OWN0: owner_onehot = 2'b01;
      ST_OWN1: owner_onehot = 2'b10;
      default: owner_onehot = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/wb_rr_pick2.sv
// Two-way round-robin pick: on a tie the master not granted last wins.
module wb_rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       vld_o,
  output logic       gnt_o
);

  assign vld_o = |req_i;
  assign gnt_o = (&req_i) ? ~last_i : req_i[1];

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone pipelined arbiter onto one shared slave, with an
// outstanding-strobe limit and a no-ack watchdog that forces an err.
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int MAX_OUTST = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_cyc,
  input  logic        i_m0_stb,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_data,
  input  logic [3:0]  i_m0_sel,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  output logic        o_m0_stall,
  output logic [31:0] o_m0_data,
  input  logic        i_m1_cyc,
  input  logic        i_m1_stb,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_data,
  input  logic [3:0]  i_m1_sel,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic        o_m1_stall,
  output logic [31:0] o_m1_data,
  output logic        o_s_cyc,
  output logic        o_s_stb,
  output logic        o_s_we,
  output logic [31:0] o_s_addr,
  output logic [31:0] o_s_data,
  output logic [3:0]  o_s_sel,
  input  logic        i_s_ack,
  input  logic        i_s_err,
  input  logic        i_s_stall,
  input  logic [31:0] i_s_data,
  output logic [1:0]  o_owner
);

  localparam logic [2:0] MAX_C = 3'(MAX_OUTST);
  localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  wb_req_t m0_req, m1_req, own_req;
  state_e  state_q, state_d;
  logic    last_q;
  logic [2:0]     outst_q, outst_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [1:0]     owner_q;
  logic own0, own1, below_max, accept, resp, wd_fire, pick_vld, pick_gnt;

  assign m0_req = '{cyc: i_m0_cyc, stb: i_m0_stb, we: i_m0_we,
                    addr: i_m0_addr, data: i_m0_data, sel: i_m0_sel};
  assign m1_req = '{cyc: i_m1_cyc, stb: i_m1_stb, we: i_m1_we,
                    addr: i_m1_addr, data: i_m1_data, sel: i_m1_sel};

  assign own0      = (state_q == ST_OWN0);
  assign own1      = (state_q == ST_OWN1);
  assign own_req   = own0 ? m0_req : (own1 ? m1_req : '0);
  assign below_max = (outst_q < MAX_C);

  assign o_s_cyc  = own_req.cyc;
  assign o_s_stb  = own_req.cyc & own_req.stb & below_max;
  assign o_s_we   = own_req.we;
  assign o_s_addr = own_req.addr;
  assign o_s_data = own_req.data;
  assign o_s_sel  = own_req.sel;

  // Responses with nothing in flight are stale (e.g. from a previous owner).
  assign accept  = o_s_stb & ~i_s_stall;
  assign resp    = (i_s_ack | i_s_err) & ((outst_q != 3'd0) | accept);
  assign wd_fire = (TIMEOUT != 0) && (outst_q != 3'd0) && !resp && (wd_q == WD_LAST);

  assign o_m0_ack   = own0 & resp & i_s_ack;
  assign o_m1_ack   = own1 & resp & i_s_ack;
  assign o_m0_err   = own0 & ((resp & i_s_err) | wd_fire);
  assign o_m1_err   = own1 & ((resp & i_s_err) | wd_fire);
  assign o_m0_stall = ~(own0 & ~i_s_stall & below_max);
  assign o_m1_stall = ~(own1 & ~i_s_stall & below_max);
  assign o_m0_data  = own0 ? i_s_data : '0;
  assign o_m1_data  = own1 ? i_s_data : '0;
  assign o_owner    = owner_q;

  wb_rr_pick2 u_pick (
    .req_i  ({i_m1_cyc, i_m0_cyc}),
    .last_i (last_q),
    .vld_o  (pick_vld),
    .gnt_o  (pick_gnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_vld) state_d = pick_gnt ? ST_OWN1 : ST_OWN0;
      ST_OWN0: if (!i_m0_cyc) state_d = i_m1_cyc ? ST_OWN1 : ST_IDLE;
      ST_OWN1: if (!i_m1_cyc) state_d = i_m0_cyc ? ST_OWN0 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    if (accept && !resp && below_max)          outst_d = outst_q + 3'd1;
    else if (!accept && resp && outst_q != 3'd0) outst_d = outst_q - 3'd1;

    wd_d = (outst_q != 3'd0 && !resp) ? wd_q + 1'b1 : '0;

    if (wd_fire) begin
      outst_d = accept ? 3'd1 : 3'd0;
      wd_d    = '0;
    end
    // Any ownership change abandons whatever the old owner had in flight.
    if (state_d != state_q) begin
      outst_d = '0;
      wd_d    = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      outst_q <= '0;
      wd_q    <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      wd_q    <= wd_d;
      owner_q <= owner_onehot(state_d);
      if (state_d == ST_OWN0)      last_q <= 1'b0;
      else if (state_d == ST_OWN1) last_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 (MAX_OUTST=3, TIMEOUT=4).
module tb_wb_arbiter2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_addr, m0_data, m1_addr, m1_data;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_sel;
  logic        s_ack, s_err, s_stall;
  logic [31:0] s_rdata;
  logic [1:0]  owner;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter2 #(.MAX_OUTST(3), .TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we),
    .i_m0_addr(m0_addr), .i_m0_data(m0_data), .i_m0_sel(m0_sel),
    .o_m0_ack(m0_ack), .o_m0_err(m0_err), .o_m0_stall(m0_stall), .o_m0_data(m0_rdata),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we),
    .i_m1_addr(m1_addr), .i_m1_data(m1_data), .i_m1_sel(m1_sel),
    .o_m1_ack(m1_ack), .o_m1_err(m1_err), .o_m1_stall(m1_stall), .o_m1_data(m1_rdata),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we),
    .o_s_addr(s_addr), .o_s_data(s_wdata), .o_s_sel(s_sel),
    .i_s_ack(s_ack), .i_s_err(s_err), .i_s_stall(s_stall), .i_s_data(s_rdata),
    .o_owner(owner)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic clear_inputs;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
    {m0_addr, m0_data, m1_addr, m1_data} = '0;
    {m0_sel, m1_sel} = '0;
    {s_ack, s_err, s_stall} = '0;
    s_rdata = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state, with a master already requesting and a stray slave ack.
    rst = 1'b1;
    clear_inputs();
    m0_cyc = 1'b1;
    s_ack  = 1'b1;
    #2;
    chk("rst s_cyc", s_cyc, 0);
    chk("rst s_stb", s_stb, 0);
    chk("rst m0_stall", m0_stall, 1);
    chk("rst m1_stall", m1_stall, 1);
    chk("rst m0_ack", m0_ack, 0);
    chk("rst owner", owner, 0);
    tick();
    tick();
    clear_inputs();
    rst = 1'b0;

    // Single read by m0.
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h2000_0004; m0_sel = 4'hF;
    #1;
    chk("t1 idle m0_stall", m0_stall, 1);
    chk("t1 idle s_cyc", s_cyc, 0);
    tick(); #1;
    chk("t1 grant m0_stall", m0_stall, 0);
    chk("t1 grant owner", owner, 2'b01);
    chk("t1 s_stb", s_stb, 1);
    chk("t1 s_addr", s_addr, 32'h2000_0004);
    tick();
    m0_stb = 0; s_ack = 1; s_rdata = 32'hCAFE_F00D;
    #1;
    chk("t1 m0_ack", m0_ack, 1);
    chk("t1 m0_data", m0_rdata, 32'hCAFE_F00D);
    chk("t1 m1_ack", m1_ack, 0);
    chk("t1 m1_data", m1_rdata, 0);
    tick();
    s_ack = 0; m0_cyc = 0;
    #1;
    chk("t1 ack done", m0_ack, 0);
    tick(); #1;
    chk("t1 back idle", owner, 0);

    // Simultaneous request, handover, round-robin tie.
    do_reset();
    m0_cyc = 1; m1_cyc = 1;
    tick(); #1;
    chk("t2 first tie owner", owner, 2'b01);
    chk("t2 m0_stall", m0_stall, 0);
    chk("t2 m1_stall", m1_stall, 1);
    m0_cyc = 0;
    #1;
    chk("t2 drop owner held", owner, 2'b01);
    tick(); #1;
    chk("t2 handover owner", owner, 2'b10);
    chk("t2 m1_stall", m1_stall, 0);
    chk("t2 s_cyc", s_cyc, 1);
    m1_cyc = 0;
    tick();
    m0_cyc = 1; m1_cyc = 1;
    tick(); #1;
    chk("t2 second tie owner", owner, 2'b01);
    m0_cyc = 0; m1_cyc = 0;
    tick();

    // Outstanding limit with delayed acks.
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h40;
    tick(); tick(); tick();        // accepts 1..3
    tick(); #1;
    chk("t3 full stall", m0_stall, 1);
    chk("t3 full s_stb", s_stb, 0);
    tick();
    s_ack = 1;
    #1;
    chk("t3 ack cycle stall", m0_stall, 1);
    chk("t3 ack routed", m0_ack, 1);
    tick();
    s_ack = 0;
    #1;
    chk("t3 released", m0_stall, 0);
    tick();
    s_ack = 1;
    #1;
    chk("t3 refull stall", m0_stall, 1);
    tick();
    s_ack = 0;
    #1;
    chk("t3 accept5 stall", m0_stall, 0);
    tick();
    m0_stb = 0; s_ack = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3 drain ack", m0_ack, 1);
      tick();
    end
    #1;
    chk("t3 surplus ack dropped", m0_ack, 0);
    s_ack = 0; m0_cyc = 0;
    tick();

    // m1 write, then drops cyc with one outstanding; late ack discarded.
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_addr = 32'h100; m1_data = 32'h1234_5678; m1_sel = 4'h3;
    tick(); #1;
    chk("t4 s_we", s_we, 1);
    chk("t4 s_data", s_wdata, 32'h1234_5678);
    chk("t4 s_sel", s_sel, 4'h3);
    chk("t4 m1_stall", m1_stall, 0);
    chk("t4 m0_stall", m0_stall, 1);
    tick();
    m1_stb = 0; m1_cyc = 0;
    #1;
    chk("t4 owner before drop", owner, 2'b10);
    tick();
    s_ack = 1;
    #1;
    chk("t4 late m0_ack", m0_ack, 0);
    chk("t4 late m1_ack", m1_ack, 0);
    chk("t4 idle owner", owner, 0);
    s_ack = 0;
    m1_we = 0;

    // Watchdog: slave never acks.
    m0_cyc = 1; m0_stb = 1;
    tick();                         // accept cycle
    tick();
    m0_stb = 0;
    #1;
    chk("t5 no err +1", m0_err, 0);
    for (int k = 2; k < 4; k++) begin
      tick(); #1;
      chk("t5 no err early", m0_err, 0);
    end
    tick(); #1;
    chk("t5 err pulse", m0_err, 1);
    chk("t5 m1_err", m1_err, 0);
    tick(); #1;
    chk("t5 err one cycle", m0_err, 0);
    chk("t5 grant held", owner, 2'b01);
    chk("t5 stall after clear", m0_stall, 0);
    s_ack = 1;
    #1;
    chk("t5 stale ack dropped", m0_ack, 0);
    s_ack = 0; m0_cyc = 0;
    tick();

    // Reset mid-burst.
    m0_cyc = 1; m0_stb = 1;
    tick(); tick();
    rst = 1; s_ack = 1;
    #1;
    chk("t6 rst s_cyc", s_cyc, 0);
    chk("t6 rst m0_stall", m0_stall, 1);
    chk("t6 rst m1_stall", m1_stall, 1);
    chk("t6 rst m0_ack", m0_ack, 0);
    chk("t6 rst owner", owner, 0);
    tick();
    m0_stb = 0; m0_cyc = 0; s_ack = 0; rst = 0;
    #1;
    chk("t6 post owner", owner, 0);
    chk("t6 post s_cyc", s_cyc, 0);
    m0_cyc = 1;
    tick();
    s_ack = 1;
    #1;
    chk("t6 outst cleared", m0_ack, 0);
    s_ack = 0; s_stall = 1;
    #1;
    chk("t6 slave stall", m0_stall, 1);
    s_stall = 0; m0_cyc = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 The block SHALL have parameter MAX_OUTST, default 3, meaning the maximum number of accepted strobes awaiting ack (range 1..7).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning the number of cycles without ack while outstanding>0 before a forced err (0 disables the watchdog).
REQ-003 The block SHALL have port i_clk, input, 1, the single clock.
REQ-004 The block SHALL have port i_rst, input, 1, the reset (asynchronous, active-high).
REQ-005 The block SHALL have ports i_mN_cyc, i_mN_stb, i_mN_we (N=0,1), input, 1 each, the master N Wishbone cycle, strobe and write.
REQ-006 The block SHALL have ports i_mN_addr and i_mN_data, input, 32 each, the master N address and write data.
REQ-007 The block SHALL have port i_mN_sel, input, 4, the master N byte select.
REQ-008 The block SHALL have ports o_mN_ack, o_mN_err and o_mN_stall, output, 1 each, the master N ack, err and stall.
REQ-009 The block SHALL have port o_mN_data, output, 32, the master N read data.
REQ-010 The block SHALL have ports o_s_cyc, o_s_stb, o_s_we, output, 1 each, to the shared slave (on-chip BRAM).
REQ-011 The block SHALL have ports o_s_addr and o_s_data, output, 32 each, and o_s_sel, output, 4, to the shared slave.
REQ-012 The block SHALL have ports i_s_ack, i_s_err and i_s_stall, input, 1 each, from the slave.
REQ-013 The block SHALL have port i_s_data, input, 32, from the slave.
REQ-014 The block SHALL have port o_owner, output, 2, one-hot current grant (debug/perf).

Function
REQ-015 The block SHALL implement the states IDLE, OWN0 and OWN1, held in registers.
REQ-016 In IDLE with i_mN_cyc=1 the block SHALL move to OWNN on the next edge; when both request, the master not granted last SHALL win (round-robin).
REQ-017 In OWNN the block SHALL stay while i_mN_cyc=1; when i_mN_cyc=0 it SHALL go to OWN(other) if the other's cyc=1, else to IDLE.
REQ-018 When no master is granted the block SHALL drive o_s_cyc and o_s_stb to 0; when granted, o_s_cyc SHALL equal the owner's cyc.
REQ-019 When granted, o_s_stb, we, addr, data and sel SHALL be combinationally muxed from the owner; o_s_stb SHALL be forced to 0 when outstanding==MAX_OUTST.
REQ-020 o_mN_stall SHALL be 1 unless state==OWNN, i_s_stall=0 and outstanding<MAX_OUTST.
REQ-021 The outstanding counter SHALL increment on o_s_stb&~i_s_stall, decrement on i_s_ack|i_s_err, hold on both, and never exceed MAX_OUTST or go below 0.
REQ-022 i_s_ack and i_s_err SHALL be routed only to the owner and only when outstanding>0 or an accept occurs in the same cycle; otherwise they SHALL be dropped.
REQ-023 o_mN_data SHALL equal i_s_data when N is the owner, else 0.
REQ-024 On a grant change or entry to IDLE, the outstanding counter and watchdog SHALL clear, and late slave acks SHALL be discarded.
REQ-025 The watchdog SHALL count cycles with outstanding>0 and no ack/err; on reaching TIMEOUT it SHALL pulse the owner's o_mN_err for 1 cycle, clear outstanding, and the grant SHALL remain held.
REQ-026 Arbitration latency SHALL be 1 cycle from cyc rise in IDLE to the first non-stalled cycle; a handover SHALL take 0 idle cycles.

Reset
REQ-027 While i_rst=1 the block SHALL force state=IDLE, last-granted=m1 (so m0 wins first tie), outstanding=0 and watchdog=0.
REQ-028 During reset o_s_cyc, o_s_stb, o_mN_ack and o_mN_err SHALL be 0, o_mN_stall SHALL be 1 and o_owner SHALL be 0.
REQ-029 A reset asserted mid-transfer SHALL abandon it with no ack to either master.

Structure
REQ-030 A shared package SHALL hold the state enum and a wb_req struct (cyc, stb, we, addr, data, sel).
REQ-031 A sub-module wb_rr_pick2 (2-way round-robin pick from req[1:0] and last) is natural and SHALL be used.

Verification
REQ-032 After reset, m0 reads addr 0x20000004 alone: o_m0_stall=0 one cycle after cyc, o_m0_ack one cycle after accept, with o_m0_data = slave data.
REQ-033 Both masters raise cyc at once after reset: m0 is granted; when m0 drops cyc, m1 is granted the next cycle with no IDLE gap; the next tie goes to m0.
REQ-034 With MAX_OUTST=3, m0 issues 5 back-to-back strobes against a slave that delays acks: stall is asserted after the 3rd accept and released on the first ack.
REQ-035 m1 drops cyc with 1 outstanding and the ack arrives a cycle later: the ack is dropped, and neither o_m0_ack nor o_m1_ack asserts.
REQ-036 With TIMEOUT=4 and a slave that never acks: o_m0_err pulses exactly 4 cycles after the accept.
REQ-037 i_rst is asserted mid-burst: o_s_cyc goes to 0 immediately, stalls go to 1, and after release the state is IDLE with outstanding 0.
